// File: rtl/usb_tx.sv
// usb_tx: USB full-speed packet transmitter.
//
// Frames a requested packet as SYNC, PID, optional payload and CRC16. The
// framed bits are bit-stuffed and NRZI-encoded, driven on D+/D-, and ended
// with EOP (two bit times of SE0, then one bit time of J).
//
// Ports:
//   clk                 system clock
//   n_rst               asynchronous active-low reset
//   tx_packet[2:0]      request: 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 invalid
//   buffer_occupancy    bytes held in the data buffer
//   tx_packet_data      head byte of the data buffer (combinational)
//   get_tx_packet_data  pop strobe, high in the cycle a payload byte is loaded
//   d_plus_out          bus D+ drive
//   d_minus_out         bus D- drive
//   tx_transfer_active  high while a packet is on the bus
//   tx_error            one-cycle pulse on an invalid request
module usb_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       d_plus_out,
  output logic       d_minus_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  localparam int            TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
  localparam logic [6:0]    MAX_CNT   = 7'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP_SE0, S_EOP_J
  } state_e;

  function automatic logic [7:0] pid_byte(input logic [2:0] code);
    case (code)
      3'd1:    return 8'hC3;
      3'd2:    return 8'h4B;
      3'd3:    return 8'hD2;
      3'd4:    return 8'h5A;
      default: return 8'h1E;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;     // bit position within the current byte
  logic [7:0]      shift_q, shift_d; // bit [0] is the raw bit currently on the line
  logic [2:0]      code_q, code_d;
  logic [6:0]      cnt_q, cnt_d;     // payload bytes not yet loaded
  logic [15:0]     crc_q, crc_d;
  logic [2:0]      ones_q, ones_d;   // run of consecutive raw 1s
  logic            line_q, line_d;   // NRZI level, 1 = J
  logic            dp_q, dp_d, dm_q, dm_d;
  logic            active_q, active_d;
  logic            err_q, err_d;

  logic bit_end, stuff_due, data_pid, raw_emit;

  assign bit_end   = (state_q != S_IDLE) && (timer_q == LAST_TICK);
  assign stuff_due = (ones_q == 3'd6);
  assign data_pid  = (code_q == 3'd1) || (code_q == 3'd2);

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // this block leaves one unassigned, which would otherwise infer a latch.
    state_d            = state_q;
    idx_d              = idx_q;
    shift_d            = shift_q;
    code_d             = code_q;
    cnt_d              = cnt_q;
    crc_d              = crc_q;
    ones_d             = ones_q;
    line_d             = line_q;
    active_d           = active_q;
    err_d              = 1'b0;
    raw_emit           = 1'b0;
    get_tx_packet_data = 1'b0;
    timer_d            = (state_q == S_IDLE || bit_end) ? '0 : timer_q + 1'b1;

    if (state_q == S_IDLE) begin
      if (tx_packet inside {[3'd1:3'd5]}) begin
        code_d   = tx_packet;
        cnt_d    = (tx_packet == 3'd1 || tx_packet == 3'd2) ?
                   ((buffer_occupancy > MAX_CNT) ? MAX_CNT : buffer_occupancy) : 7'd0;
        state_d  = S_SYNC;
        shift_d  = 8'h80;
        idx_d    = 3'd0;
        active_d = 1'b1;
        raw_emit = 1'b1;  // first SYNC bit is a 0, which also clears the run
      end else if (tx_packet[2:1] == 2'b11) begin
        err_d = 1'b1;
      end
    end else if (bit_end) begin
      unique case (state_q)
        S_EOP_SE0: begin
          if (idx_q == 3'd0) begin
            idx_d = 3'd1;
          end else begin
            state_d = S_EOP_J;
            line_d  = 1'b1;
          end
        end
        S_EOP_J: begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end
        default: begin
          if (stuff_due) begin
            // Stuffed 0: toggles the line but holds the shifter and the CRC.
            line_d = ~line_q;
            ones_d = 3'd0;
          end else if (idx_q != 3'd7) begin
            idx_d    = idx_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            raw_emit = 1'b1;
          end else begin
            idx_d    = 3'd0;
            raw_emit = 1'b1;
            case (state_q)
              S_SYNC: begin
                state_d = S_PID;
                shift_d = pid_byte(code_q);
                crc_d   = 16'hFFFF;
              end
              S_PID, S_DATA: begin
                if (state_q == S_PID && !data_pid) begin
                  state_d  = S_EOP_SE0;
                  raw_emit = 1'b0;
                end else if (cnt_q == 7'd0) begin
                  state_d = S_CRC_LO;
                  shift_d = ~crc_q[7:0];
                end else begin
                  // Pop and load share one edge, so the strobe is decoded
                  // here rather than registered.
                  state_d            = S_DATA;
                  shift_d            = tx_packet_data;
                  cnt_d              = cnt_q - 7'd1;
                  get_tx_packet_data = 1'b1;
                end
              end
              S_CRC_LO: begin
                state_d = S_CRC_HI;
                shift_d = ~crc_q[15:8];
              end
              default: begin
                state_d  = S_EOP_SE0;
                raw_emit = 1'b0;
              end
            endcase
          end
        end
      endcase
    end

    if (raw_emit) begin
      if (!shift_d[0]) line_d = ~line_q;
      ones_d = shift_d[0] ? ones_q + 3'd1 : 3'd0;
      // Reflected CRC16 (x^16+x^15+x^2+1), payload bits only.
      if (state_d == S_DATA)
        crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ shift_d[0]) ? 16'hA001 : 16'h0000);
    end

    dp_d = (state_d == S_EOP_SE0) ? 1'b0 : line_d;
    dm_d = (state_d == S_EOP_SE0) ? 1'b0 : ~line_d;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      code_q   <= 3'd0;
      cnt_q    <= 7'd0;
      crc_q    <= 16'h0000;
      ones_q   <= 3'd0;
      line_q   <= 1'b1;
      dp_q     <= 1'b1;
      dm_q     <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      ones_q   <= ones_d;
      line_q   <= line_d;
      dp_q     <= dp_d;
      dm_q     <= dm_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign d_plus_out         = dp_q;
  assign d_minus_out        = dm_q;
  assign tx_transfer_active = active_q;
  assign tx_error           = err_q;

endmodule
